ccd_capture_stage: RTL

//  Front-end capture stage for the TRDB-D5M sensor path. Registers raw 12-bit CCD

---
 rtl/ccd_capture_stage.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/ccd_capture_stage.sv
// TRDB-D5M capture front end: registers raw CCD pixels, gates whole frames on
// start/stop commands and emits a qualified pixel stream with X/Y and markers.
module ccd_capture_stage #(
    parameter int DATA_W = 12,
    parameter int COL    = 800,
    parameter int ROW    = 600,
    parameter int XW     = 11,
    parameter int YW     = 11
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [DATA_W-1:0] iDATA,
    input  logic              iFVAL,
    input  logic              iLVAL,
    input  logic              iSTART,
    input  logic              iEND,
    output logic [DATA_W-1:0] oDATA,
    output logic              oDVAL,
    output logic [XW-1:0]     oX,
    output logic [YW-1:0]     oY,
    output logic              oSOF,
    output logic              oEOL,
    output logic              oEOF,
    output logic [31:0]       oFRAME_CNT,
    output logic              oLINE_ERR,
    output logic              oBUSY
);

    localparam logic [XW-1:0] X_LIM  = XW'(COL);
    localparam logic [XW-1:0] X_LAST = XW'(COL - 1);
    localparam logic [YW-1:0] Y_LIM  = YW'(ROW);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_ACTIVE
    } state_t;

    function automatic logic [XW-1:0] sat_inc_x(input logic [XW-1:0] v);
        return (v >= X_LIM) ? v : v + XW'(1);
    endfunction

    function automatic logic [YW-1:0] sat_inc_y(input logic [YW-1:0] v);
        return (v >= Y_LIM) ? v : v + YW'(1);
    endfunction

    state_t state_q, state_d;
    logic   run_q, run_d;

    logic [DATA_W-1:0] data_p1_q, data_p1_d;
    logic              fval_p1_q, fval_p1_d;
    logic              lval_p1_q, lval_p1_d;
    logic              fval_prev_q, fval_prev_d;
    logic              line_prev_q, line_prev_d;

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          x_ovf_q, x_ovf_d;

    logic [DATA_W-1:0] data_p2_q, data_p2_d;
    logic              dval_p2_q, dval_p2_d;
    logic [XW-1:0]     x_p2_q, x_p2_d;
    logic [YW-1:0]     y_p2_q, y_p2_d;
    logic              sof_p2_q, sof_p2_d;
    logic              eol_p2_q, eol_p2_d;
    logic              eof_p2_q, eof_p2_d;
    logic [31:0]       frame_cnt_q, frame_cnt_d;
    logic              line_err_q, line_err_d;

    logic          line_p1;
    logic          fval_rise;
    logic          fval_fall;
    logic          line_close;
    logic          capture;
    logic          accept;
    logic          line_bad;
    logic [YW-1:0] y_cur;

    always_comb begin
        data_p1_d   = iDATA;
        fval_p1_d   = iFVAL;
        lval_p1_d   = iLVAL;

        // A line only exists inside FVAL, so an FVAL drop also closes an open line.
        line_p1     = fval_p1_q & lval_p1_q;
        fval_rise   = fval_p1_q & ~fval_prev_q;
        fval_fall   = ~fval_p1_q & fval_prev_q;
        line_close  = line_prev_q & ~line_p1;
        fval_prev_d = fval_p1_q;
        line_prev_d = line_p1;

        run_d = run_q;
        if (iEND) begin
            run_d = 1'b0;
        end else if (iSTART) begin
            run_d = 1'b1;
        end

        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (run_q) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (!run_q) begin
                    state_d = S_IDLE;
                end else if (fval_rise) begin
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (fval_fall) state_d = run_q ? S_ARMED : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // The FVAL-rise cycle itself belongs to the new frame, with Y already at 0.
        capture = (state_q == S_ACTIVE) || ((state_q == S_ARMED) && run_q && fval_rise);
        y_cur   = fval_rise ? '0 : y_q;
        accept  = capture && line_p1 && (x_q < X_LIM) && (y_cur < Y_LIM);

        x_d     = '0;
        x_ovf_d = 1'b0;
        if (line_p1) begin
            x_d     = sat_inc_x(x_q);
            x_ovf_d = x_ovf_q | (x_q >= X_LIM);
        end

        y_d = y_q;
        if (fval_rise) begin
            y_d = '0;
        end else if (line_close && (x_q != '0)) begin
            y_d = sat_inc_y(y_q);
        end

        // X saturates at COL, so an over-long line is caught by the overflow flag.
        line_bad = (state_q == S_ACTIVE) && line_close && (x_q != '0) &&
                   ((x_q != X_LIM) || x_ovf_q);

        // Stage 2: output register
        dval_p2_d = accept;
        data_p2_d = accept ? data_p1_q : '0;
        x_p2_d    = accept ? x_q : '0;
        y_p2_d    = accept ? y_cur : '0;
        sof_p2_d  = accept && (x_q == '0) && (y_cur == '0);
        eol_p2_d  = accept && (x_q == X_LAST);
        eof_p2_d  = (state_q == S_ACTIVE) && fval_fall;

        frame_cnt_d = frame_cnt_q;
        if (eof_p2_d) frame_cnt_d = frame_cnt_q + 32'd1;

        line_err_d = line_err_q;
        if (sof_p2_d) line_err_d = 1'b0;
        if (line_bad) line_err_d = 1'b1;
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q     <= S_IDLE;
            run_q       <= 1'b0;
            data_p1_q   <= '0;
            fval_p1_q   <= 1'b0;
            lval_p1_q   <= 1'b0;
            fval_prev_q <= 1'b0;
            line_prev_q <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            x_ovf_q     <= 1'b0;
            data_p2_q   <= '0;
            dval_p2_q   <= 1'b0;
            x_p2_q      <= '0;
            y_p2_q      <= '0;
            sof_p2_q    <= 1'b0;
            eol_p2_q    <= 1'b0;
            eof_p2_q    <= 1'b0;
            frame_cnt_q <= '0;
            line_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            data_p1_q   <= data_p1_d;
            fval_p1_q   <= fval_p1_d;
            lval_p1_q   <= lval_p1_d;
            fval_prev_q <= fval_prev_d;
            line_prev_q <= line_prev_d;
            x_q         <= x_d;
            y_q         <= y_d;
            x_ovf_q     <= x_ovf_d;
            data_p2_q   <= data_p2_d;
            dval_p2_q   <= dval_p2_d;
            x_p2_q      <= x_p2_d;
            y_p2_q      <= y_p2_d;
            sof_p2_q    <= sof_p2_d;
            eol_p2_q    <= eol_p2_d;
            eof_p2_q    <= eof_p2_d;
            frame_cnt_q <= frame_cnt_d;
            line_err_q  <= line_err_d;
        end
    end

    assign oDATA      = data_p2_q;
    assign oDVAL      = dval_p2_q;
    assign oX         = x_p2_q;
    assign oY         = y_p2_q;
    assign oSOF       = sof_p2_q;
    assign oEOL       = eol_p2_q;
    assign oEOF       = eof_p2_q;
    assign oFRAME_CNT = frame_cnt_q;
    assign oLINE_ERR  = line_err_q;
    assign oBUSY      = (state_q == S_ACTIVE);

endmodule
